multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle sequencer for the MIPS datapath. It replaces single-cycle control decode with a state machine that shares one ALU and one unified memory port across the fetch, decode, execute, memory and writeback steps. It sits beside the ALU, the ALU-control decoder (which it drives with a 3-bit ALUOp), the register file and the PC register. It also absorbs variable memory latency through a ready handshake.

## Interface
- No parameters.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_en  out  1  PC register load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread / memwrite  out  1 each  memory strobes, held until mem_ready.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = reg A.
- alusrcb  out  2  ALU B select: 00 = reg B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop  out  3  000 = ADD, 001 = SUB, 010 = use funct.
- pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- Unlisted outputs are 0 in every state. aluop defaults to ADD.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, pcsource=00.
  - irwrite = pc_en = mem_ready.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut).
  - lw/sw → MEMADR; R → EXEC; beq/bne → BRANCH; j → JUMP.
  - Any other opcode: illegal=1 this cycle, next state FETCH.
- MEMADR: alusrca=1, alusrcb=10, ADD. lw → MEMRD; sw → MEMWR.
- MEMRD: iord=1, memread=1. Waits for mem_ready, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1. Waits for mem_ready, then → FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=010. Next state ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsource=01.
  - pc_en = (beq & zero) | (bne & ~zero).
  - Next state FETCH.
- JUMP: pcsource=10, pc_en=1. Next state FETCH.
- The opcode is sampled combinationally. It is stable after FETCH because irwrite is asserted only there.

## Timing
- State register updates on the clock rising edge.
- Mux selects and aluop are Moore outputs of the state register.
- pc_en, irwrite and illegal are Mealy outputs (gated by mem_ready, zero or opcode).
- Zero-wait latency (mem_ready always 1): R-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. The strobe and address select are held constant while waiting.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset: while reset_n=0 is sampled, state ← FETCH. All enables and strobes (pc_en, irwrite, regwrite, memread, memwrite, illegal) are forced to 0 that cycle.
  - Reset mid-instruction abandons the instruction with no register or memory write.
  - The first cycle after release is FETCH with memread=1.
- Reset has priority over every transition, including mem_ready arriving in the same cycle.

## Configuration
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: adds output ports cycle_count (32) and instr_count (32), both reset to 0.
  - cycle_count increments every cycle that reset_n=1.
  - instr_count increments on every transition into FETCH from another state, including illegal.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and the counter logic are absent. Everything else is identical.

## Structure
- Package multicycle_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - the ALUOp, alusrcb and pcsource encodings.
- The package is shared with ula_ctrl and the datapath top.
- One sub-module, multicycle_ctrl_perf, holds the two counters. It is instantiated only under MULTICYCLE_CTRL_PERF_EN.

## Test plan
- R-type add with mem_ready=1 → states FETCH, DECODE, EXEC, ALUWB. regwrite=1 and regdst=1 in cycle 4 only; then back to FETCH.
- lw with mem_ready held 0 for 2 cycles in MEMRD → memread and iord stay 1 for 3 cycles. Total latency 7; regwrite with memtoreg=1 in the last cycle.
- beq with zero=1 → pc_en=1 and pcsource=01 in cycle 3. bne with zero=1 → pc_en=0 in cycle 3.
- opcode 111111 → illegal=1 for exactly one cycle in DECODE; back in FETCH the next cycle; no regwrite or memwrite.
- reset_n=0 asserted in MEMWR while mem_ready=1 → memwrite=0 that cycle; next state FETCH.
- With MULTICYCLE_CTRL_PERF_EN and three j instructions → cycle_count=9 and instr_count=3. A counter preset to 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared state codes, opcodes and datapath select encodings
package multicycle_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_EXEC   = 4'd6;
    localparam state_t S_ALUWB  = 4'd7;
    localparam state_t S_BRANCH = 4'd8;
    localparam state_t S_JUMP   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] ASB_REGB   = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_perf.sv
// multicycle_ctrl_perf: free-running cycle and retired-instruction counters
module multicycle_ctrl_perf
    import multicycle_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enter_fetch,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    logic [31:0] cycle_q, instr_q;

    // count every live cycle and every return to FETCH; both wrap naturally
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            instr_q <= instr_q + {31'd0, enter_fetch};
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: MIPS multicycle control FSM (optional counters via MULTICYCLE_CTRL_PERF_EN)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  aluop,
    output logic [1:0]  pcsource,
    output logic        illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    state_t state_q, state_d;
    logic   pc_en_c, irwrite_c, regwrite_c, memread_c, memwrite_c, illegal_c;

    wire is_mem = (opcode == OP_LW) || (opcode == OP_SW);
    wire is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    wire is_r   = opcode == OP_RTYPE;
    wire is_j   = opcode == OP_J;

    // state register; reset wins over any pending transition
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // next state, Moore selects and ungated Mealy enables
    always_comb begin
        state_d    = state_q;
        pc_en_c    = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        illegal_c  = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ASB_REGB;
        aluop      = ALUOP_ADD;
        pcsource   = PCS_ALU;
        case (state_q)
            S_FETCH: begin
                memread_c = 1'b1;
                alusrcb   = ASB_FOUR;
                irwrite_c = mem_ready;
                pc_en_c   = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb   = ASB_IMM_SH;
                illegal_c = !(is_mem || is_r || is_br || is_j);
                state_d   = is_mem ? S_MEMADR : is_r ? S_EXEC : is_br ? S_BRANCH : is_j ? S_JUMP : S_FETCH;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ASB_IMM;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                memread_c = 1'b1;
                state_d   = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsource = PCS_ALUOUT;
                pc_en_c  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsource = PCS_JUMP;
                pc_en_c  = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_en    = reset_n & pc_en_c;
    assign irwrite  = reset_n & irwrite_c;
    assign regwrite = reset_n & regwrite_c;
    assign memread  = reset_n & memread_c;
    assign memwrite = reset_n & memwrite_c;
    assign illegal  = reset_n & illegal_c;

`ifdef MULTICYCLE_CTRL_PERF_EN
    multicycle_ctrl_perf u_perf (
        .clock       (clock),
        .reset_n     (reset_n),
        .enter_fetch ((state_q != S_FETCH) && (state_d == S_FETCH)),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven and hand-sequenced checks of the control FSM outputs
module tb_multicycle_ctrl;

    logic        clock, reset_n, zero, mem_ready;
    logic [5:0]  opcode;
    logic        pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
    logic [1:0]  alusrcb, pcsource;
    logic [2:0]  aluop;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    multicycle_ctrl dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    logic [16:0] sb_q[$];

    typedef struct packed {
        logic [5:0]       opc;
        logic             z;
        logic [2:0]       n;
        logic [4:0][16:0] e;
    } vec_t;
    vec_t tbl[10];

    // {pc_en,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsource,illegal}
    function automatic logic [16:0] mk(input logic pe, io, mr, mw, irw, rd, mtr, rw, asa,
                                       input logic [1:0] asb, input logic [2:0] aop,
                                       input logic [1:0] pcs, input logic ill);
        return {pe, io, mr, mw, irw, rd, mtr, rw, asa, asb, aop, pcs, ill};
    endfunction

    wire [16:0] act = {pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                       alusrca, alusrcb, aluop, pcsource, illegal};

    logic [16:0] F1, F0, DEC, DECI, MA, MRD, MWB, MWR, EX, AWB, BR1, BR0, JMP, RST_F, RST_MWR;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    // one cycle: drive, sample mid-cycle against the head of the scoreboard, advance
    task automatic cyc(input string nm, input logic rdy, input logic rst_n);
        logic [16:0] e;
        mem_ready = rdy;
        reset_n = rst_n;
        #2;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sb_q.pop_front();
            chk(nm, {15'd0, act}, {15'd0, e});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string nm, input logic rdy, input logic rst_n, input logic [16:0] e);
        sb_q.push_back(e);
        cyc(nm, rdy, rst_n);
    endtask

    task automatic set_vec(input int i, input logic [5:0] opc, input logic z, input logic [2:0] n,
                           input logic [16:0] e0, e1, e2, e3, e4);
        tbl[i].opc = opc;
        tbl[i].z = z;
        tbl[i].n = n;
        tbl[i].e[0] = e0;
        tbl[i].e[1] = e1;
        tbl[i].e[2] = e2;
        tbl[i].e[3] = e3;
        tbl[i].e[4] = e4;
    endtask

    initial begin
        F1      = mk(1,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00,0);
        F0      = mk(0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0);
        DEC     = mk(0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0);
        DECI    = mk(0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,1);
        MA      = mk(0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
        MRD     = mk(0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
        MWB     = mk(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0);
        MWR     = mk(0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
        EX      = mk(0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0);
        AWB     = mk(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
        BR1     = mk(1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0);
        BR0     = mk(0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0);
        JMP     = mk(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0);
        RST_F   = mk(0,0,0,0,0,0,0,0,0,2'b01,3'b000,2'b00,0);
        RST_MWR = mk(0,1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);

        set_vec(0, 6'b000000, 0, 4, F1, DEC, EX,  AWB, 0);
        set_vec(1, 6'b100011, 0, 5, F1, DEC, MA,  MRD, MWB);
        set_vec(2, 6'b101011, 0, 4, F1, DEC, MA,  MWR, 0);
        set_vec(3, 6'b000100, 1, 3, F1, DEC, BR1, 0,   0);
        set_vec(4, 6'b000100, 0, 3, F1, DEC, BR0, 0,   0);
        set_vec(5, 6'b000101, 1, 3, F1, DEC, BR0, 0,   0);
        set_vec(6, 6'b000101, 0, 3, F1, DEC, BR1, 0,   0);
        set_vec(7, 6'b000010, 0, 3, F1, DEC, JMP, 0,   0);
        set_vec(8, 6'b111111, 0, 2, F1, DECI, 0,  0,   0);
        set_vec(9, 6'b001000, 1, 2, F1, DECI, 0,  0,   0);

        reset_n = 1'b0;
        opcode = 6'b000000;
        zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock);
        #1;
        step("reset_hold", 1'b1, 1'b0, RST_F);

        for (int i = 0; i < 10; i++) begin
            opcode = tbl[i].opc;
            zero = tbl[i].z;
            for (int k = 0; k < int'(tbl[i].n); k++) sb_q.push_back(tbl[i].e[k]);
            for (int k = 0; k < int'(tbl[i].n); k++) cyc($sformatf("vec%0d_c%0d", i, k), 1'b1, 1'b1);
        end

        opcode = 6'b100011;
        step("lw_f", 1, 1, F1);
        step("lw_d", 1, 1, DEC);
        step("lw_ma", 1, 1, MA);
        step("lw_rd_wait0", 0, 1, MRD);
        step("lw_rd_wait1", 0, 1, MRD);
        step("lw_rd_done", 1, 1, MRD);
        step("lw_wb", 1, 1, MWB);

        opcode = 6'b101011;
        step("sw_f_wait", 0, 1, F0);
        step("sw_f", 1, 1, F1);
        step("sw_d", 1, 1, DEC);
        step("sw_ma", 1, 1, MA);
        step("sw_wr_wait", 0, 1, MWR);
        step("sw_wr", 1, 1, MWR);

        opcode = 6'b000000;
        step("r_ign_f", 1, 1, F1);
        step("r_ign_d", 0, 1, DEC);
        step("r_ign_ex", 0, 1, EX);
        step("r_ign_wb", 0, 1, AWB);

        opcode = 6'b101011;
        step("rst_sw_f", 1, 1, F1);
        step("rst_sw_d", 1, 1, DEC);
        step("rst_sw_ma", 1, 1, MA);
        step("rst_in_memwr", 1, 0, RST_MWR);
        step("rst_after_f", 1, 1, F1);
        step("rst_after_d", 1, 1, DEC);
        step("rst_after_ma", 1, 1, MA);
        step("rst_after_wr", 1, 1, MWR);
        step("rst_after_next_f", 1, 1, F1);

`ifdef MULTICYCLE_CTRL_PERF_EN
        step("perf_rst", 1, 0, RST_F);
        chk("perf_rst_cycles", cycle_count, 32'd0);
        chk("perf_rst_instr", instr_count, 32'd0);
        opcode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            step("perf_j_f", 1, 1, F1);
            step("perf_j_d", 1, 1, DEC);
            step("perf_j_j", 1, 1, JMP);
        end
        chk("perf_cycles", cycle_count, 32'd9);
        chk("perf_instr", instr_count, 32'd3);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
